// File: rtl/riscv_pkg.sv
// Definitions shared by the riscv core and its memory responder: bus width,
// the canonical NOP encoding and the memory-side FSM states.
package riscv_pkg;

  localparam int BUS_WIDTH = 32;
  localparam logic [BUS_WIDTH-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic {
    MEM_INIT,
    MEM_READY
  } mem_state_e;

endpackage

// File: rtl/riscv_word_ram.sv
// Word-organised memory array with a combinational read port and a
// synchronous write port; used for both IMEM and DMEM.
module riscv_word_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // The core samples the read data on the edge that ends its request cycle.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/riscv_mem_responder.sv
// Memory-side responder for the riscv core: serves fetches, loads and stores,
// zero-fills DMEM after reset, tracks sticky access errors and access counts.
module riscv_mem_responder
  import riscv_pkg::*;
#(
  parameter int BUS_WIDTH  = riscv_pkg::BUS_WIDTH,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256,
  parameter int CNT_WIDTH  = 16,
  parameter logic [BUS_WIDTH-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iwr,
  input  logic [BUS_WIDTH-1:0] iaddr,
  input  logic [BUS_WIDTH-1:0] i_wdata,
  output logic [BUS_WIDTH-1:0] idata,
  input  logic                 re,
  input  logic                 wr,
  input  logic [BUS_WIDTH-1:0] addr,
  input  logic [BUS_WIDTH-1:0] data_out,
  output logic [BUS_WIDTH-1:0] data_in,
  output logic                 init_done,
  output logic                 err_align,
  output logic                 err_range,
  output logic [CNT_WIDTH-1:0] load_cnt,
  output logic [CNT_WIDTH-1:0] store_cnt
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  mem_state_e           state_q, state_d;
  logic [DAW-1:0]       ptr_q, ptr_d;
  logic                 err_align_q, err_align_d;
  logic                 err_range_q, err_range_d;
  logic [CNT_WIDTH-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_WIDTH-1:0] store_cnt_q, store_cnt_d;

  logic [BUS_WIDTH-1:0] i_word, d_word;
  logic                 i_aligned, i_in_range, i_ok;
  logic                 d_aligned, d_in_range, d_ok;
  logic                 ready, load_ok, store_ok;
  logic                 imem_we, dmem_we;
  logic [DAW-1:0]       dmem_waddr;
  logic [BUS_WIDTH-1:0] dmem_wdata, imem_rdata, dmem_rdata;

  // Every upper address bit takes part in the range check, so nothing aliases.
  assign i_word     = iaddr >> 2;
  assign d_word     = addr >> 2;
  assign i_aligned  = (iaddr[1:0] == 2'b00);
  assign d_aligned  = (addr[1:0] == 2'b00);
  assign i_in_range = (i_word < BUS_WIDTH'(IMEM_DEPTH));
  assign d_in_range = (d_word < BUS_WIDTH'(DMEM_DEPTH));
  assign i_ok       = i_aligned & i_in_range;
  assign d_ok       = d_aligned & d_in_range;

  assign ready    = (state_q == MEM_READY);
  assign load_ok  = ready & re & d_ok;
  assign store_ok = ready & wr & d_ok;
  assign imem_we  = reset & iwr & i_ok;

  riscv_word_ram #(.WIDTH(BUS_WIDTH), .DEPTH(IMEM_DEPTH)) u_imem (
    .clk   (clk),
    .we    (imem_we),
    .waddr (i_word[IAW-1:0]),
    .wdata (i_wdata),
    .raddr (i_word[IAW-1:0]),
    .rdata (imem_rdata)
  );

  riscv_word_ram #(.WIDTH(BUS_WIDTH), .DEPTH(DMEM_DEPTH)) u_dmem (
    .clk   (clk),
    .we    (dmem_we),
    .waddr (dmem_waddr),
    .wdata (dmem_wdata),
    .raddr (d_word[DAW-1:0]),
    .rdata (dmem_rdata)
  );

  // The DMEM write port belongs to the zero-fill during INIT and to stores after.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    dmem_we    = 1'b0;
    dmem_waddr = d_word[DAW-1:0];
    dmem_wdata = data_out;
    case (state_q)
      MEM_INIT: begin
        dmem_we    = reset;
        dmem_waddr = ptr_q;
        dmem_wdata = '0;
        ptr_d      = ptr_q + 1'b1;
        if (ptr_q == DAW'(DMEM_DEPTH - 1)) begin
          state_d = MEM_READY;
        end
      end
      MEM_READY: dmem_we = reset & store_ok;
      default:   state_d = MEM_INIT;
    endcase
  end

  always_comb begin
    err_align_d = err_align_q | ((re | wr) & ~d_aligned) | ~i_aligned;
    err_range_d = err_range_q | ((re | wr) & ~d_in_range) | ~i_in_range
                | (wr & ~ready);
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    if (load_ok && (load_cnt_q != '1)) begin
      load_cnt_d = load_cnt_q + 1'b1;
    end
    if (store_ok && (store_cnt_q != '1)) begin
      store_cnt_d = store_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= MEM_INIT;
      ptr_q       <= '0;
      err_align_q <= 1'b0;
      err_range_q <= 1'b0;
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      err_align_q <= err_align_d;
      err_range_q <= err_range_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  assign idata     = i_ok ? imem_rdata : NOP_INSTR;
  assign data_in   = load_ok ? dmem_rdata : '0;
  assign init_done = ready;
  assign err_align = err_align_q;
  assign err_range = err_range_q;
  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Directed plus randomized checks of riscv_mem_responder against a
// word-array reference model that tracks time since reset.
module tb_riscv_mem_responder;

  localparam int DEPTH = 256;
  localparam int CMAX  = 15;

  logic        clk = 1'b0;
  logic        reset, iwr, re, wr;
  logic [31:0] iaddr, i_wdata, addr, data_out;
  logic [31:0] idata, data_in;
  logic        init_done, err_align, err_range;
  logic [3:0]  load_cnt, store_cnt;

  riscv_mem_responder #(
    .BUS_WIDTH(32), .IMEM_DEPTH(DEPTH), .DMEM_DEPTH(DEPTH),
    .CNT_WIDTH(4), .NOP_INSTR(32'h00000013)
  ) dut (
    .clk(clk), .reset(reset), .iwr(iwr), .iaddr(iaddr), .i_wdata(i_wdata),
    .idata(idata), .re(re), .wr(wr), .addr(addr), .data_out(data_out),
    .data_in(data_in), .init_done(init_done), .err_align(err_align),
    .err_range(err_range), .load_cnt(load_cnt), .store_cnt(store_cnt)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [31:0] m_dmem [DEPTH];
  logic [31:0] m_imem [DEPTH];
  bit          m_ivalid [DEPTH];
  int          m_since_reset = 0;
  bit          m_err_a, m_err_r;
  int          m_ld, m_st;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic bit m_ready();
    return m_since_reset >= DEPTH;
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return (a >> 2) < 32'(DEPTH);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic iw, input logic [31:0] ia, input logic [31:0] iwd,
                     input logic rst_n);
    bit dok, iok, rdy;
    logic [31:0] exp_di;
    re = r; wr = w; addr = a; data_out = d;
    iwr = iw; iaddr = ia; i_wdata = iwd; reset = rst_n;
    dok = (a[1:0] == 2'b00) && in_rng(a);
    iok = (ia[1:0] == 2'b00) && in_rng(ia);
    rdy = m_ready();
    #1;
    exp_di = (rdy && r && dok) ? m_dmem[a[9:2]] : 32'h0;
    chk("data_in", data_in, exp_di);
    if (!iok) chk("idata_nop", idata, 32'h00000013);
    else if (m_ivalid[ia[9:2]]) chk("idata", idata, m_imem[ia[9:2]]);

    @(posedge clk);
    if (!rst_n) begin
      m_since_reset = 0;
      m_err_a = 0; m_err_r = 0; m_ld = 0; m_st = 0;
      for (int i = 0; i < DEPTH; i++) m_dmem[i] = 32'h0;
    end else begin
      if ((r || w) && a[1:0] != 2'b00) m_err_a = 1;
      if ((r || w) && !in_rng(a)) m_err_r = 1;
      if (w && !rdy) m_err_r = 1;
      if (ia[1:0] != 2'b00) m_err_a = 1;
      if (!in_rng(ia)) m_err_r = 1;
      if (iw && iok) begin
        m_imem[ia[9:2]] = iwd;
        m_ivalid[ia[9:2]] = 1;
      end
      if (rdy && r && dok && m_ld < CMAX) m_ld++;
      if (rdy && w && dok) begin
        m_dmem[a[9:2]] = d;
        if (m_st < CMAX) m_st++;
      end
      if (!rdy) m_since_reset++;
    end
    #1;
    chk("init_done", {31'b0, init_done}, {31'b0, m_ready()});
    chk("err_align", {31'b0, err_align}, {31'b0, m_err_a});
    chk("err_range", {31'b0, err_range}, {31'b0, m_err_r});
    chk("load_cnt", {28'b0, load_cnt}, 32'(m_ld));
    chk("store_cnt", {28'b0, store_cnt}, 32'(m_st));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 1);
  endtask

  initial begin
    // 1: reset, zero-fill takes DMEM_DEPTH cycles, then a top-word load
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    idle(DEPTH);
    cyc(1, 0, 32'h3FC, 0, 0, 0, 0, 1);

    // 2: store then load back
    cyc(0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 1);
    cyc(1, 0, 32'h10, 0, 0, 0, 0, 1);

    // 3: misaligned store dropped, out-of-range load
    cyc(0, 1, 32'h12, 32'h12345678, 0, 0, 0, 1);
    cyc(1, 0, 32'h10, 0, 0, 0, 0, 1);
    cyc(1, 0, 32'h400, 0, 0, 0, 0, 1);
    cyc(1, 1, 32'h10, 32'hCAFEF00D, 0, 0, 0, 1);
    cyc(1, 0, 32'h10, 0, 0, 0, 0, 1);

    // 4: program load, fetch back, out-of-range fetch
    cyc(0, 0, 0, 0, 1, 32'h8, 32'h00500093, 1);
    cyc(0, 0, 0, 0, 0, 32'h8, 0, 1);
    cyc(0, 0, 0, 0, 0, 32'h400, 0, 1);
    cyc(0, 0, 0, 0, 0, 32'h6, 0, 1);

    // 5: store during INIT, restart mid-fill, DMEM cleared afterwards
    cyc(0, 0, 0, 0, 0, 32'h8, 0, 0);
    cyc(0, 1, 32'h0, 32'h55, 0, 32'h8, 0, 1);
    idle(99);
    cyc(0, 0, 0, 0, 0, 32'h8, 0, 0);
    idle(DEPTH);
    cyc(1, 0, 32'h0, 0, 0, 0, 0, 1);
    cyc(1, 0, 32'h10, 0, 0, 0, 0, 1);

    // 6: counter saturation
    for (int i = 0; i < 20; i++) cyc(1, 1, 32'(i % 8) << 2, $urandom, 0, 0, 0, 1);

    // randomized traffic after a fresh reset
    cyc(0, 0, 0, 0, 0, 32'h8, 0, 0);
    idle(DEPTH);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, ia;
      a  = ($urandom_range(0, 9) != 0) ? (32'($urandom_range(0, 15)) << 2) : $urandom;
      ia = ($urandom_range(0, 9) != 0) ? (32'($urandom_range(0, 15)) << 2) : $urandom;
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), a, $urandom,
          1'($urandom_range(0, 3) == 0), ia, $urandom, 1);
    end

    // final reset: flags and counters clear, IMEM retained
    cyc(0, 0, 0, 0, 0, 32'h8, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 0, 32'(i) << 2, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
